// File: rtl/definitions_pkg.sv
// Shared types for the Sobel front end: image geometry, pixel/window payloads, window FSM states.
package definitions_pkg;

  localparam int unsigned IMG_WIDTH  = 512;
  localparam int unsigned IMG_HEIGHT = 512;
  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned WIN_TAPS   = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [WIN_TAPS-1:0] window_t;
  // One window column: [0] = row r-2, [1] = row r-1, [2] = row r.
  typedef pixel_t [2:0] column_t;

  typedef enum logic {
    FILL   = 1'b0,
    ACTIVE = 1'b1
  } win_state_e;

  // Byte (row*3 + col) of the window; col 0 is the oldest column.
  function automatic window_t pack_window(input column_t c_m2, input column_t c_m1,
                                          input column_t c_0);
    window_t w;
    for (int r = 0; r < 3; r++) begin
      w[r*3+0] = c_m2[r];
      w[r*3+1] = c_m1[r];
      w[r*3+2] = c_0[r];
    end
    return w;
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel stream in / 3x3 window stream out between a pixel source and the window generator.
interface sobel_window_gen_if;

  definitions_pkg::pixel_t  pixel_in;
  logic                     pixel_in_valid;
  definitions_pkg::window_t window_data;
  logic                     window_valid;

  modport master (
    output pixel_in,
    output pixel_in_valid,
    input  window_data,
    input  window_valid
  );

  modport slave (
    input  pixel_in,
    input  pixel_in_valid,
    output window_data,
    output window_valid
  );

endinterface

// File: rtl/line_buffer.sv
// One-line pixel store: asynchronous read, synchronous write, so a same-cycle read sees the old value.
module line_buffer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data_c = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel stream to 3x3 Sobel windows using two line buffers and a column shift register.
// Optional frame_done output enabled by macro WINDOW_FRAME_DONE_EN.
module sobel_window_gen
  import definitions_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_WIDTH,
  parameter int unsigned IMG_H = IMG_HEIGHT
) (
  input  logic clk,
  input  logic rst,
`ifdef WINDOW_FRAME_DONE_EN
  output logic frame_done,
`endif
  sobel_window_gen_if.slave pix_if
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  win_state_e       state;
  column_t          col_m2, col_m1, col_new_c;
  pixel_t           lb1_rd_c, lb2_rd_c;
  logic             accept_c, last_col_c, last_row_c, emit_c;

  always_comb begin
    accept_c   = pix_if.pixel_in_valid;
    last_col_c = (col_cnt == COL_W'(IMG_W - 1));
    last_row_c = (row_cnt == ROW_W'(IMG_H - 1));
    emit_c     = accept_c && (state == ACTIVE) && (col_cnt >= COL_W'(2));
    col_new_c  = {pix_if.pixel_in, lb1_rd_c, lb2_rd_c};
  end

  // Row r-1 store: takes the incoming pixel.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W)) u_lb_r1 (
    .clk       (clk),
    .wr_en     (accept_c),
    .wr_addr   (col_cnt),
    .wr_data   (pix_if.pixel_in),
    .rd_addr   (col_cnt),
    .rd_data_c (lb1_rd_c)
  );

  // Row r-2 store: takes the value displaced from the row r-1 store.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W)) u_lb_r2 (
    .clk       (clk),
    .wr_en     (accept_c),
    .wr_addr   (col_cnt),
    .wr_data   (lb1_rd_c),
    .rd_addr   (col_cnt),
    .rd_data_c (lb2_rd_c)
  );

  // Two previous columns; stale contents across a line wrap are never emitted.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      col_m2 <= col_m1;
      col_m1 <= col_new_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt             <= '0;
      row_cnt             <= '0;
      state               <= FILL;
      pix_if.window_data  <= '0;
      pix_if.window_valid <= 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
      frame_done          <= 1'b0;
`endif
    end else begin
      pix_if.window_valid <= emit_c;
      if (emit_c) begin
        pix_if.window_data <= pack_window(col_m2, col_m1, col_new_c);
      end
`ifdef WINDOW_FRAME_DONE_EN
      frame_done <= emit_c && last_col_c && last_row_c;
`endif
      if (accept_c) begin
        if (last_col_c) begin
          col_cnt <= '0;
          if (last_row_c) begin
            row_cnt <= '0;
            state   <= FILL;
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
            if (row_cnt == ROW_W'(1)) begin
              state <= ACTIVE;
            end
          end
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on an 8x6 image: scenario table plus reset corner cases.
// Expected windows come from a frame-array reference model; WINDOW_FRAME_DONE_EN adds frame_done checks.
module tb_sobel_window_gen;
  import definitions_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;

  typedef struct {
    int kind;      // 0 ramp, 1 all 0xFF, 2 random
    int gap;       // 0 continuous, 1 alternate idle, 2 random idle
    int frames;
    int exp_win;
    int first_b8;  // -1 skips first/last byte-8 checks
    int last_b8;
  } scen_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if u_if ();
`ifdef WINDOW_FRAME_DONE_EN
  logic frame_done;
`endif

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef WINDOW_FRAME_DONE_EN
    .frame_done (frame_done),
`endif
    .pix_if     (u_if)
  );

  int      checks = 0;
  int      errors = 0;
  int      win_total = 0;
  pixel_t  frame_px [H][W];
  window_t exp_q [$];
  bit      exp_fd_q [$];
  window_t got_q [$];
  window_t model_hold;
  logic    rst_q;
  scen_t   tbl [6];

  always @(posedge clk) rst_q <= rst;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic fill_frame(input int kind);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        case (kind)
          0:       frame_px[r][c] = pixel_t'(r * int'(W) + c);
          1:       frame_px[r][c] = 8'hFF;
          default: frame_px[r][c] = pixel_t'($urandom);
        endcase
  endtask

  // Reference: every full 3x3 neighbourhood ending at a pixel index below n_px.
  task automatic push_expected(input int n_px);
    window_t w;
    for (int r = 2; r < int'(H); r++)
      for (int c = 2; c < int'(W); c++)
        if (r * int'(W) + c < n_px) begin
          for (int i = 0; i < 9; i++) w[i] = frame_px[r - 2 + i / 3][c - 2 + i % 3];
          exp_q.push_back(w);
          exp_fd_q.push_back(r == int'(H) - 1 && c == int'(W) - 1);
        end
  endtask

  task automatic drive_pixels(input int n_px, input int gap);
    int idle;
    for (int idx = 0; idx < n_px; idx++) begin
      u_if.pixel_in       = frame_px[idx / int'(W)][idx % int'(W)];
      u_if.pixel_in_valid = 1'b1;
      @(posedge clk);
      #1;
      u_if.pixel_in_valid = 1'b0;
      idle = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (idle) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic monitor();
    window_t w;
    bit      fd;
    forever begin
      @(negedge clk);
      if (rst_q === 1'b1) model_hold = '0;
      if (u_if.window_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window got valid=1 exp valid=0 data %h", u_if.window_data);
        end else begin
          w  = exp_q.pop_front();
          fd = exp_fd_q.pop_front();
          check("window_data", u_if.window_data, w);
`ifdef WINDOW_FRAME_DONE_EN
          check("frame_done", 72'(frame_done), 72'(fd));
`endif
          model_hold = w;
        end
        got_q.push_back(u_if.window_data);
        win_total++;
      end else begin
        check("hold_data", u_if.window_data, model_hold);
`ifdef WINDOW_FRAME_DONE_EN
        check("frame_done_idle", 72'(frame_done), 72'(0));
`endif
      end
    end
  endtask

  initial begin
    int base;
    tbl[0] = '{0, 0, 1, 24, 18, 47};
    tbl[1] = '{0, 1, 1, 24, 18, 47};
    tbl[2] = '{0, 0, 2, 48, 18, 47};
    tbl[3] = '{1, 0, 1, 24, 255, 255};
    tbl[4] = '{2, 2, 2, 48, -1, -1};
    tbl[5] = '{0, 2, 1, 24, 18, 47};

    rst                 = 1'b1;
    u_if.pixel_in       = '0;
    u_if.pixel_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 72'(u_if.window_valid), 72'(0));
    check("reset_data", u_if.window_data, 72'(0));
`ifdef WINDOW_FRAME_DONE_EN
    check("reset_frame_done", 72'(frame_done), 72'(0));
`endif
    model_hold = '0;
    fork
      monitor();
    join_none

    foreach (tbl[s]) begin
      got_q.delete();
      base = win_total;
      for (int f = 0; f < tbl[s].frames; f++) begin
        fill_frame(tbl[s].kind);
        push_expected(int'(W * H));
        drive_pixels(int'(W * H), tbl[s].gap);
      end
      drain();
      check($sformatf("win_count_s%0d", s), 72'(win_total - base), 72'(tbl[s].exp_win));
      if (tbl[s].first_b8 >= 0 && got_q.size() > 0) begin
        check($sformatf("first_b8_s%0d", s), 72'(got_q[0][8]), 72'(tbl[s].first_b8));
        check($sformatf("last_b8_s%0d", s), 72'(got_q[got_q.size() - 1][8]),
              72'(tbl[s].last_b8));
      end
    end

    // Reset mid-frame after 30 pixels, then a fresh frame.
    fill_frame(0);
    push_expected(30);
    drive_pixels(30, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("valid_after_rst", 72'(u_if.window_valid), 72'(0));
    check("data_after_rst", u_if.window_data, 72'(0));
    check("pending_after_rst", 72'(exp_q.size()), 72'(0));
    got_q.delete();
    base = win_total;
    push_expected(int'(W * H));
    drive_pixels(int'(W * H), 0);
    drain();
    check("win_count_after_rst", 72'(win_total - base), 72'(24));
    if (got_q.size() > 0) check("first_b8_after_rst", 72'(got_q[0][8]), 72'(18));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default IMG_WIDTH (512), meaning pixels per line.
REQ-002 SHALL have parameter IMG_H, default IMG_HEIGHT (512), meaning lines per frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port pixel_in, input, 8, grayscale pixel, raster order.
REQ-006 SHALL have port pixel_in_valid, input, 1, pixel_in accepted on every cycle this is high; no backpressure.
REQ-007 SHALL have port window_data, output, 72, packed 3x3 window feeding gradient_data_in.
REQ-008 SHALL have port window_valid, output, 1, feeding gradient_data_in_valid.
REQ-009 SHALL have port frame_done, output, 1, present only under WINDOW_FRAME_DONE_EN.

Function
REQ-010 SHALL track col_cnt 0..IMG_W-1 and row_cnt 0..IMG_H-1; both advance only on accepted pixels; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1 (frame end).
REQ-011 SHALL hold two line buffers (rows r-1, r-2) of IMG_W x 8 bits plus a 3x3 shift register of the three most recent columns.
REQ-012 SHALL, per accepted pixel at column c, read both buffers at c, write pixel into row r-1 buffer at c and the old row r-1 value into row r-2 buffer at c (read-before-write same cycle).
REQ-013 SHALL pack byte i (bits i*8+:8), i=0..8, as window row i/3, column i%3; byte 0 = pixel (r-2,c-2), byte 4 = centre (r-1,c-1), byte 8 = (r,c).
REQ-014 SHALL run FSM FILL -> ACTIVE: FILL while row_cnt<2; ACTIVE for rows 2..IMG_H-1; return to FILL on frame-end wrap.
REQ-015 SHALL assert window_valid for exactly one cycle, one cycle after accepting a pixel with state ACTIVE and col_cnt>=2; otherwise low.
REQ-016 SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows per frame; no window spans two lines or two frames.
REQ-017 SHALL hold window_data stable when window_valid is low.
REQ-018 SHALL tolerate arbitrary gaps in pixel_in_valid with identical window content and count.
REQ-019 SHALL, on the last pixel of a frame followed immediately by the next frame's first pixel, start the next frame in FILL with no lost or extra cycles.

Reset
REQ-020 SHALL, with rst high at a clock edge, clear col_cnt, row_cnt, window_data, window_valid, frame_done, set FSM to FILL; line-buffer contents need not be cleared.
REQ-021 SHALL, on reset mid-frame, drop the partial frame; the next accepted pixel is (0,0) of a new frame.

Configuration
REQ-022 SHALL gate the feature with macro WINDOW_FRAME_DONE_EN.
REQ-023 With WINDOW_FRAME_DONE_EN defined: frame_done pulses one cycle, coincident with the window_valid of window (IMG_H-1, IMG_W-1).
REQ-024 Without it: port frame_done and its logic are absent; all other behaviour identical.

Structure
REQ-025 SHALL take IMG_WIDTH, IMG_HEIGHT, pixel_t (8-bit) and window state enum from definitions_pkg.
REQ-026 SHALL instantiate line buffers as sub-module line_buffer (depth IMG_W, 8-bit, one read + one write per cycle), two instances.

Verification (IMG_W=8, IMG_H=6)
REQ-027 Ramp frame pixel=r*8+c, continuous valid -> 24 windows; first = bytes {0,1,2,8,9,10,16,17,18}, valid one cycle after pixel 18; last byte8=47.
REQ-028 Same ramp with valid low every other cycle -> identical 24 windows, same order.
REQ-029 Two back-to-back ramp frames -> 48 windows; frame 2 first window again {0..18 pattern}, none mixing frames.
REQ-030 rst after 30 pixels, then fresh ramp -> window_valid 0 the cycle after rst; 24 correct windows follow.
REQ-031 All-0xFF frame -> every window_data = 72'hFF..FF; downstream gradient_magnitude 0.
REQ-032 With WINDOW_FRAME_DONE_EN -> one frame_done pulse per frame, aligned to window byte8=47; without macro, port absent, REQ-027 passes unchanged.
